// File: rtl/console_pkg.sv
// Shared console types: transmit-mux FSM states and the ASCII control bytes it recognises.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_mux_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO with registered full/empty; head is visible on pop_data while not empty.
// Writes while full and reads while empty are ignored; push and pop in one cycle keep the count.
module byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count_q;
  logic [AW:0]           count_d;
  logic                  do_push;
  logic                  do_pop;

  // full is taken from the registered count, so a push into a full FIFO is lost even when a pop frees a slot
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      full    <= (count_d == (AW + 1)'(FIFO_DEPTH));
      empty   <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_mux.sv
// Round-robin merge of NUM_SRC byte FIFOs onto the transmitter start/busy handshake; src_valid to tx_start is 2 cycles.
// Writes to a full source are dropped and flagged in sticky overflow; TX_MUX_CRLF_EN makes every CR be followed by an LF.
module uart_tx_mux
  import console_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_full,
  output logic [NUM_SRC-1:0]            overflow,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic                          idle
);

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  tx_mux_state_t         state_q;
  tx_mux_state_t         state_d;
  logic [GW-1:0]         last_grant_q;
  logic [GW-1:0]         grant;
  logic [CW-1:0]         tmo_q;
  logic [CW-1:0]         tmo_d;
  logic [NUM_SRC-1:0]    fifo_empty;
  logic [NUM_SRC-1:0]    fifo_full;
  logic [NUM_SRC-1:0]    pop;
  logic [DATA_WIDTH-1:0] head [NUM_SRC];
  logic                  any_ready;
  logic                  load_head;
  logic                  load_lf;
  logic                  crlf_due;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    byte_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (src_valid[g]),
      .push_data(src_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop      (pop[g]),
      .pop_data (head[g]),
      .full     (fifo_full[g]),
      .empty    (fifo_empty[g])
    );
  end

  assign src_full  = fifo_full;
  assign any_ready = ~&fifo_empty;

`ifdef TX_MUX_CRLF_EN
  assign crlf_due = (tx_data == DATA_WIDTH'(ASCII_CR));
`else
  assign crlf_due = 1'b0;
`endif

  // first non-empty source after the previous grant, wrapping around
  always_comb begin
    logic          found;
    logic [GW-1:0] cand;
    grant = last_grant_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_SRC);
      if (!found && !fifo_empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pop       = '0;
    load_head = 1'b0;
    load_lf   = 1'b0;
    tx_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && any_ready) begin
          pop[grant] = 1'b1;
          load_head  = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        tmo_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // a transmitter that never answers still counts as having sent the byte
          if (tmo_d == CW'(BUSY_TIMEOUT)) begin
            load_lf = crlf_due;
            state_d = crlf_due ? ISSUE : IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          load_lf = crlf_due;
          state_d = crlf_due ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_SRC - 1);
      tmo_q        <= '0;
      tx_data      <= '0;
      overflow     <= '0;
      idle         <= 1'b1;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (load_head) begin
        tx_data      <= head[grant];
        last_grant_q <= grant;
      end else if (load_lf) begin
        tx_data <= DATA_WIDTH'(ASCII_LF);
      end
      overflow <= overflow | (src_valid & fifo_full);
      idle     <= (&fifo_empty) && (state_q == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_mux.sv
// Directed and randomized checks of uart_tx_mux against a queue-based round-robin reference model.
module tb_uart_tx_mux;

  localparam int NS    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BT    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_full;
  logic [NS-1:0]    overflow;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_busy;
  logic             idle;

  logic hold_hi;
  logic resp_busy;
  logic resp_en;
  int   frame_len;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] sent[$];
  int         start_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] mq[NS][$];
  logic [NS-1:0] m_ovf;
  int            m_last;

  assign tx_busy = hold_hi | resp_busy;

  uart_tx_mux #(
    .NUM_SRC     (NS),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_full (src_full),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0 && tx_start === 1'b1) begin
      sent.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
  end

  // transmitter model: busy rises the cycle after a start pulse and stays up for frame_len cycles
  initial begin
    resp_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && resp_en) begin
        @(posedge clk);
        #1 resp_busy = 1'b1;
        repeat (frame_len) @(posedge clk);
        #1 resp_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_sent(input string tag);
    check({tag, " count"}, sent.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      check($sformatf("%s byte%0d", tag, i), {24'h0, sent[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic step(input logic [NS-1:0] v, input logic [NS*DW-1:0] d);
    src_valid = v;
    src_data  = d;
    @(posedge clk);
    #1;
    src_valid = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    while (idle !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " drained"}, {31'h0, idle}, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sent.delete();
    start_cyc.delete();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_ovf  = '0;
    m_last = NS - 1;
  endtask

  // reference: drain all queues one byte at a time, cycling from the source after the last one served
  task automatic model_drain();
    logic [7:0] b;
    bit any;
    exp_q.delete();
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 1; k <= NS; k++) begin
        int idx;
        idx = (m_last + k) % NS;
        if (!any && mq[idx].size() > 0) begin
          b = mq[idx].pop_front();
          exp_q.push_back(b);
          m_last = idx;
          any = 1'b1;
`ifdef TX_MUX_CRLF_EN
          if (b == 8'h0D) exp_q.push_back(8'h0A);
`endif
        end
      end
    end
  endtask

  initial begin
    int c0;
    logic [NS-1:0]    v;
    logic [NS*DW-1:0] d;

    rst       = 1'b1;
    src_valid = '0;
    src_data  = '0;
    hold_hi   = 1'b0;
    resp_en   = 1'b1;
    frame_len = 10;
    #3;
    check("reset tx_start", {31'h0, tx_start}, 32'h0);
    check("reset tx_data", {24'h0, tx_data}, 32'h0);
    check("reset src_full", {30'h0, src_full}, 32'h0);
    check("reset overflow", {30'h0, overflow}, 32'h0);
    check("reset idle", {31'h0, idle}, 32'h1);

    // single byte with 2-cycle latency
    do_reset();
    c0 = cyc;
    step(2'b01, {8'h00, 8'h41});
    wait_idle("single");
    check("single starts", start_cyc.size(), 1);
    if (start_cyc.size() > 0) check("single latency", start_cyc[0] - c0, 2);
    exp_q = '{8'h41};
    cmp_sent("single");

    // round-robin between two preloaded sources
    do_reset();
    frame_len = 3;
    hold_hi = 1'b1;
    step(2'b11, {8'h61, 8'h30});
    step(2'b11, {8'h62, 8'h31});
    hold_hi = 1'b0;
    wait_idle("rr");
    exp_q = '{8'h30, 8'h61, 8'h31, 8'h62};
    cmp_sent("rr");

    // overflow on a depth-4 FIFO
    do_reset();
    hold_hi = 1'b1;
    step(2'b01, {8'h00, 8'h01});
    step(2'b01, {8'h00, 8'h02});
    step(2'b01, {8'h00, 8'h03});
    check("ovf full after 3", {30'h0, src_full}, 32'h0);
    step(2'b01, {8'h00, 8'h04});
    check("ovf full after 4", {30'h0, src_full}, 32'h1);
    check("ovf flag before drop", {30'h0, overflow}, 32'h0);
    step(2'b01, {8'h00, 8'h05});
    check("ovf flag after drop", {30'h0, overflow}, 32'h1);
    hold_hi = 1'b0;
    wait_idle("ovf");
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    cmp_sent("ovf");
    check("ovf sticky", {30'h0, overflow}, 32'h1);
    check("ovf full cleared", {30'h0, src_full}, 32'h0);

    // transmitter never raises busy
    do_reset();
    resp_en = 1'b0;
    step(2'b01, {8'h00, 8'h11});
    step(2'b01, {8'h00, 8'h12});
    wait_idle("tmo");
    check("tmo starts", start_cyc.size(), 2);
    if (start_cyc.size() == 2) check("tmo spacing", start_cyc[1] - start_cyc[0], BT + 2);
    exp_q = '{8'h11, 8'h12};
    cmp_sent("tmo");
    resp_en = 1'b1;

    // reset while waiting for the transmitter to finish, with three bytes still queued
    do_reset();
    frame_len = 20;
    step(2'b01, {8'h00, 8'hA1});
    step(2'b01, {8'h00, 8'hA2});
    step(2'b01, {8'h00, 8'hA3});
    step(2'b01, {8'h00, 8'hA4});
    repeat (3) @(posedge clk);
    #1;
    check("midrst busy before", {31'h0, tx_busy}, 32'h1);
    check("midrst idle before", {31'h0, idle}, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst tx_start", {31'h0, tx_start}, 32'h0);
    check("midrst tx_data", {24'h0, tx_data}, 32'h0);
    check("midrst idle", {31'h0, idle}, 32'h1);
    check("midrst src_full", {30'h0, src_full}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sent.delete();
    repeat (30) @(posedge clk);
    #1;
    check("midrst no start", sent.size(), 0);
    check("midrst idle after", {31'h0, idle}, 32'h1);

    // CR from source 1 then a byte from source 0
    do_reset();
    frame_len = 3;
    step(2'b10, {8'h0D, 8'h00});
    step(2'b01, {8'h00, 8'h42});
    wait_idle("crlf");
`ifdef TX_MUX_CRLF_EN
    exp_q = '{8'h0D, 8'h0A, 8'h42};
`else
    exp_q = '{8'h0D, 8'h42};
`endif
    cmp_sent("crlf");

    // randomized rounds: load with the transmitter held busy, then drain against the model
    do_reset();
    for (int r = 0; r < 8; r++) begin
      hold_hi = 1'b1;
      sent.delete();
      repeat ($urandom_range(3, 12)) begin
        v = NS'($urandom);
        for (int i = 0; i < NS; i++) begin
          d[i*DW +: DW] = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom);
          if (v[i]) begin
            if (mq[i].size() == DEPTH) m_ovf[i] = 1'b1;
            else mq[i].push_back(d[i*DW +: DW]);
          end
        end
        step(v, d);
        for (int i = 0; i < NS; i++)
          check($sformatf("rnd%0d full%0d", r, i), {31'h0, src_full[i]}, {31'h0, mq[i].size() == DEPTH});
        check($sformatf("rnd%0d overflow", r), {30'h0, overflow}, {30'h0, m_ovf});
      end
      model_drain();
      resp_en   = ($urandom_range(0, 2) != 0);
      frame_len = $urandom_range(2, 6);
      hold_hi   = 1'b0;
      wait_idle($sformatf("rnd%0d", r));
      cmp_sent($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d ovf sticky", r), {30'h0, overflow}, {30'h0, m_ovf});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_mux.md
Name: uart_tx_mux

Overview:
Parametrised successor to the single-source keyboard-to-UART path. Merges NUM_SRC byte streams (keyboard ASCII, button macros, loopback, ...) into the single async_transmitter start/busy handshake. Each source has its own FIFO, and sources are served round-robin. Sits between the input decoders and the UART transmitter in the top level.

Parameters:
NUM_SRC, 2, number of byte sources (1..8)
DATA_WIDTH, 8, byte width
FIFO_DEPTH, 16, entries per source FIFO (power of two, >=2)
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
src_valid  in  NUM_SRC  per-source one-cycle write strobe
src_data  in  NUM_SRC*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
src_full  out  NUM_SRC  per-source FIFO full, registered
overflow  out  NUM_SRC  sticky: a write to that source was dropped
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  DATA_WIDTH  byte to transmit, stable from tx_start until return to IDLE
tx_busy  in  1  transmitter busy
idle  out  1  all FIFOs empty and FSM in IDLE

Behaviour:
- Reset (async, any state): tx_start=0, tx_data=0, src_full=0, overflow=0, idle=1. All FIFOs empty. FSM=IDLE. last_grant=NUM_SRC-1, so source 0 is served first.
- Write: on src_valid[i] with src_full[i]==0, the byte is pushed at that edge.
  - With src_full[i]==1 the byte is dropped and overflow[i] is set.
  - overflow clears only on rst.
  - src_full is derived from the registered count. A push while full is dropped even if a pop happens in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO are both performed; the count is unchanged.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if tx_busy==0 and any FIFO is non-empty:
    - grant the first non-empty source searching cyclically from last_grant+1;
    - pop its head into tx_data; update last_grant; go to ISSUE.
    - If tx_busy==1, stay in IDLE.
  - ISSUE: tx_start=1 for exactly this cycle; go to WAIT_BUSY with timeout counter=0.
  - WAIT_BUSY: on tx_busy==1 go to WAIT_DONE. Otherwise increment the counter; at BUSY_TIMEOUT go to IDLE (byte considered sent).
  - WAIT_DONE: on tx_busy==0 go to IDLE.
- Latency: from src_valid in cycle 0 with the FSM idle and tx_busy low, tx_start is high in cycle 2 (push edge 0, grant/pop edge 1).
- Throughput: one byte per transmitter frame. No source is served twice while another non-empty source waits.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- idle is registered and updates one cycle after the condition holds.

Optional Feature:
TX_MUX_CRLF_EN
- Defined: when the byte just issued equals 0x0D, the FSM returns from WAIT_DONE (or timeout) into ISSUE with tx_data=0x0A instead of going to IDLE. No re-arbitration happens and no FIFO pop occurs for the inserted 0x0A.
- Undefined: 0x0D is passed through like any other byte and no bytes are inserted.

Decomposition:
- Package console_pkg holds:
  - the FSM state enum tx_mux_state_t;
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- One sub-module, byte_fifo (DATA_WIDTH, FIFO_DEPTH). It has push, pop, data in/out, full, empty, async active-high rst, and registered full/empty. It is instantiated NUM_SRC times via generate.

Test Plan:
- Single byte: src_valid[0] with 0x41 at cycle 0; busy model raises tx_busy 1 cycle after start for 10 cycles -> exactly one tx_start pulse at cycle 2, tx_data=0x41, idle=1 after busy falls.
- Round-robin: preload src0={0x30,0x31} and src1={0x61,0x62} with tx_busy held high, then release -> transmit order 0x30,0x61,0x31,0x62.
- Overflow: FIFO_DEPTH=4, tx_busy held 1, five writes of 0x01..0x05 to src0 -> src_full[0]=1 after the 4th, 0x05 dropped, overflow[0]=1. After release: 0x01..0x04 sent, overflow[0] stays 1.
- Busy timeout: tx_busy stuck 0, two bytes queued -> second tx_start occurs BUSY_TIMEOUT+2 cycles after the first, with no hang.
- Reset mid-frame: assert rst in WAIT_DONE with 3 bytes queued -> all outputs reset in the same cycle, FIFOs empty, no tx_start after release.
- CRLF: src1=0x0D, src0=0x42 queued -> with TX_MUX_CRLF_EN: 0x0D,0x0A,0x42; without: 0x0D,0x42.
